// File: rtl/mtime_ctrl_pkg.sv
// Shared constants for the mtime bus controller: register map, CTRL bits, FSM encoding.
// Imported by the controller and its comparator; holds no logic of its own.
package mtime_ctrl_pkg;

  localparam logic [2:0] MT_ADDR_MTIME_L = 3'd0;
  localparam logic [2:0] MT_ADDR_MTIME_H = 3'd1;
  localparam logic [2:0] MT_ADDR_CMP_L   = 3'd2;
  localparam logic [2:0] MT_ADDR_CMP_H   = 3'd3;
  localparam logic [2:0] MT_ADDR_CTRL    = 3'd4;

  localparam int          CTRL_IRQ_EN = 0;
  localparam logic [63:0] CMP_RST_DEF = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_WSEQ0 = 3'd2,
    ST_WSEQ1 = 3'd3,
    ST_WSEQ2 = 3'd4
  } state_e;

  // Low-half strobe is driven in the first and last step of the carry-safe write.
  function automatic logic strobe_lo(input state_e s);
    return (s == ST_WSEQ0) || (s == ST_WSEQ2);
  endfunction

endpackage

// File: rtl/mtime_ctrl_if.sv
// Req/ready slave bus for the mtime controller; master holds sel/we/addr/wdata until ready.
// rdata is meaningful only in the single cycle ready is high.
interface mtime_ctrl_if;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output sel, we, addr, wdata, input rdata, ready);
  modport slave  (input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mtime_ctrl_cmp64.sv
// Registered 64-bit unsigned mtime >= mtimecmp compare, gated by the interrupt enable.
// One cycle from counter/compare/enable change to timer_irq; level output.
module mtime_cmp64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [63:0] mtime_i,
  input  logic [63:0] cmp_i,
  output logic        irq_o
);
  logic irq_q, irq_d;

  assign irq_d = en_i & (mtime_i >= cmp_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq_o = irq_q;
endmodule

// File: rtl/mtime_ctrl.sv
// Bus controller for the 64-bit mtime counter: tear-free reads, carry-safe L,H,L writes, mtimecmp IRQ.
// Non-sequenced accesses ack one cycle after accept; an MTIME_L write acks on the third cycle.
module mtime_ctrl
  import mtime_ctrl_pkg::*;
#(
  parameter logic [63:0] CMP_RST = CMP_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mtime_ctrl_if.slave bus,
  input  logic [31:0] mtimerl_i,
  input  logic [31:0] mtimerh_i,
  output logic [31:0] mtimer_o,
  output logic        wrl_n,
  output logic        wrh_n,
  output logic        timer_irq
);
  state_e      state_q, state_d;
  logic        accept;
  logic [31:0] shadow_hi_q, snap_hi_q, wlo_q;
  logic [63:0] cmp_q;
  logic        irq_en_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mtimer_q, mtimer_d;
  logic        ready_q, ready_d;
  logic        wrl_n_q, wrl_n_d;
  logic        wrh_n_q, wrh_n_d;

  assign accept = (state_q == ST_IDLE) && bus.sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.sel) begin
          if (bus.we && bus.addr == MT_ADDR_MTIME_L) state_d = ST_WSEQ0;
          else                                       state_d = ST_ACK;
        end
      end
      ST_ACK:   state_d = ST_IDLE;
      ST_WSEQ0: state_d = ST_WSEQ1;
      ST_WSEQ1: state_d = ST_WSEQ2;
      ST_WSEQ2: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the strobes leave a flop aligned with the state.
  always_comb begin
    wrl_n_d  = ~strobe_lo(state_d);
    wrh_n_d  = (state_d != ST_WSEQ1);
    ready_d  = (state_d == ST_ACK) || (state_d == ST_WSEQ2);
    mtimer_d = '0;
    case (state_d)
      ST_WSEQ1: mtimer_d = shadow_hi_q;
      ST_WSEQ2: mtimer_d = wlo_q;
      default:  mtimer_d = '0;
    endcase
    rdata_d = '0;
    if (accept && !bus.we) begin
      case (bus.addr)
        MT_ADDR_MTIME_L: rdata_d = mtimerl_i;
        MT_ADDR_MTIME_H: rdata_d = snap_hi_q;
        MT_ADDR_CMP_L:   rdata_d = cmp_q[31:0];
        MT_ADDR_CMP_H:   rdata_d = cmp_q[63:32];
        MT_ADDR_CTRL:    rdata_d = {31'b0, irq_en_q};
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_hi_q <= '0;
      snap_hi_q   <= '0;
      wlo_q       <= '0;
      cmp_q       <= CMP_RST;
      irq_en_q    <= 1'b0;
      rdata_q     <= '0;
      mtimer_q    <= '0;
      ready_q     <= 1'b0;
      wrl_n_q     <= 1'b1;
      wrh_n_q     <= 1'b1;
    end else begin
      rdata_q  <= rdata_d;
      mtimer_q <= mtimer_d;
      ready_q  <= ready_d;
      wrl_n_q  <= wrl_n_d;
      wrh_n_q  <= wrh_n_d;
      if (accept && bus.we) begin
        case (bus.addr)
          MT_ADDR_MTIME_L: wlo_q         <= bus.wdata;
          MT_ADDR_MTIME_H: shadow_hi_q   <= bus.wdata;
          MT_ADDR_CMP_L:   cmp_q[31:0]   <= bus.wdata;
          MT_ADDR_CMP_H:   cmp_q[63:32]  <= bus.wdata;
          MT_ADDR_CTRL:    irq_en_q      <= bus.wdata[CTRL_IRQ_EN];
          default:         ;
        endcase
      end else if (accept && bus.addr == MT_ADDR_MTIME_L) begin
        // High half frozen with the low-half read so a following MTIME_H read cannot tear.
        snap_hi_q <= mtimerh_i;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign mtimer_o  = mtimer_q;
  assign wrl_n     = wrl_n_q;
  assign wrh_n     = wrh_n_q;

  mtime_cmp64 u_cmp (
    .clk     (clk),
    .rst     (rst),
    .en_i    (irq_en_q),
    .mtime_i ({mtimerh_i, mtimerl_i}),
    .cmp_i   (cmp_q),
    .irq_o   (timer_irq)
  );
endmodule
